// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter sequencer: FSM encoding and
// the per-bit toggle-chain helper used to build up/down count masks.
package tff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } tff_state_e;

  // Carry of the toggle chain into the next bit: a bit toggles only when every
  // lower bit is all-ones (counting up) or all-zeros (counting down).
  function automatic logic mask_chain(input logic carry, input logic q_bit,
                                      input logic up);
    return carry & (up ? q_bit : ~q_bit);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles its output whenever t is high at the clock edge.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= q ^ t;
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Sequences a bank of T flip-flop cells as a programmable up/down counter with
// optional preload, a tick budget, abort, and busy/done/wrap status.
module tff_count_sequencer
  import tff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_up,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] ticks,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  tff_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode_q;
  logic [WIDTH-1:0] load_val_q;
  logic             latch;
  logic             step;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] run_mask;

  assign run_mask[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign run_mask[i] = mask_chain(run_mask[i-1], q[i-1], mode_q);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    t       = '0;
    latch   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          rem_d = ticks;
          // A preload always happens when requested, even with a zero budget.
          if (load_en)            state_d = ST_LOAD;
          else if (ticks == '0)   state_d = ST_DONE;
          else                    state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          t       = q ^ load_val_q;
          state_d = (rem_q == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          t    = run_mask;
          step = 1'b1;
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (rem_q <= CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (latch) mode_q <= mode_up;
      wrap    <= step & (mode_q ? (&q) : ~(|q));
    end
  end

  always_ff @(posedge clk) begin
    if (latch) load_val_q <= load_val;
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: reset, up/down counting, preload,
// wrap pulses, zero-tick runs, abort and start-while-busy.
module tb_tff_count_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, mode_up, load_en;
  logic [7:0]  load_val;
  logic [15:0] ticks;
  logic [7:0]  q;
  logic        busy, done, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  tff_count_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode_up  (mode_up),
    .load_en  (load_en),
    .load_val (load_val),
    .ticks    (ticks),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] eq, input logic eb,
                     input logic ed, input logic ew);
    check_val({tag, ".q"},    32'(q),    32'(eq));
    check_val({tag, ".busy"}, 32'(busy), 32'(eb));
    check_val({tag, ".done"}, 32'(done), 32'(ed));
    check_val({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic go(input logic up, input logic ld, input logic [7:0] lv,
                    input logic [15:0] tk);
    mode_up = up; load_en = ld; load_val = lv; ticks = tk; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_up = 1'b0;
    load_en = 1'b0; load_val = '0; ticks = '0;
    #12;
    chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Async reset mid-run at q=05
    go(1'b1, 1'b0, 8'h00, 16'd10);
    repeat (5) tick();
    check_val("pre_rst.q", 32'(q), 32'h05);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Up count 3 from 0
    go(1'b1, 1'b0, 8'h00, 16'd3);
    chk("up.E0", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk("up.E1", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); chk("up.E2", 8'h02, 1'b1, 1'b0, 1'b0);
    tick(); chk("up.E3", 8'h03, 1'b0, 1'b1, 1'b0);
    tick(); chk("up.idle", 8'h03, 1'b0, 1'b0, 1'b0);

    // Load 02 then down 4 steps across zero
    go(1'b0, 1'b1, 8'h02, 16'd4);
    chk("dn.E0", 8'h03, 1'b1, 1'b0, 1'b0);
    tick(); chk("dn.E1", 8'h02, 1'b1, 1'b0, 1'b0);
    tick(); chk("dn.E2", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); chk("dn.E3", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk("dn.E4", 8'hFF, 1'b1, 1'b0, 1'b1);
    tick(); chk("dn.E5", 8'hFE, 1'b0, 1'b1, 1'b0);
    tick(); chk("dn.idle", 8'hFE, 1'b0, 1'b0, 1'b0);

    // Load FE then up 2 steps across all-ones
    go(1'b1, 1'b1, 8'hFE, 16'd2);
    chk("upw.E0", 8'hFE, 1'b1, 1'b0, 1'b0);
    tick(); chk("upw.E1", 8'hFE, 1'b1, 1'b0, 1'b0);
    tick(); chk("upw.E2", 8'hFF, 1'b1, 1'b0, 1'b0);
    tick(); chk("upw.E3", 8'h00, 1'b0, 1'b1, 1'b1);
    tick(); chk("upw.idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Zero ticks with and without preload
    go(1'b1, 1'b1, 8'hA5, 16'd0);
    chk("z.ld.E0", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk("z.ld.E1", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick(); chk("z.ld.idle", 8'hA5, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 8'h3C, 16'd0);
    chk("z.nold.E0", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick(); chk("z.nold.idle", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Abort on the 4th step cycle, with an ignored start while busy
    go(1'b1, 1'b1, 8'h00, 16'd10);
    tick(); chk("ab.E1", 8'h00, 1'b1, 1'b0, 1'b0);
    mode_up = 1'b0; load_en = 1'b1; load_val = 8'h77; ticks = 16'd1; start = 1'b1;
    tick(); chk("ab.E2", 8'h01, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); chk("ab.E3", 8'h02, 1'b1, 1'b0, 1'b0);
    tick(); chk("ab.E4", 8'h03, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick(); chk("ab.E5", 8'h03, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    tick(); chk("ab.idle", 8'h03, 1'b0, 1'b0, 1'b0);

    // Abort in IDLE is harmless; fresh start after abort works
    abort = 1'b1;
    tick(); chk("ab.inidle", 8'h03, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    go(1'b1, 1'b0, 8'h00, 16'd1);
    chk("re.E0", 8'h03, 1'b1, 1'b0, 1'b0);
    tick(); chk("re.E1", 8'h04, 1'b0, 1'b1, 1'b0);
    tick(); chk("re.idle", 8'h04, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
